lsu_mem_responder: RTL and testbench
====================================

Name: lsu_mem_responder

Overview:
- Memory-side responder for the LSU load/store path.
- Accepts one byte-masked read or write request at a time over a valid/ready request channel.
- Services the request after a fixed programmable latency against an internal 64-bit-wide word array.
- Returns read data or a write acknowledgement over a valid/ready response channel.
- Replaces the zero-latency DPI memory model in simulation, so the core sees realistic multi-cycle memory.

Parameters:
DEPTH, 1024, number of 64-bit words in the internal array (power of two)
BASE, 64'h8000_0000, byte address of word 0
LATENCY, 2, cycles from request acceptance to resp_valid (must be >= 1)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_addr  in  64  byte address
req_wen  in  1  1 = store, 0 = load
req_wdata  in  64  store data, right-aligned (byte 0 = lowest byte)
req_wmask  in  8  byte-length mask, right-aligned: 0x01, 0x03, 0x0F or 0xFF
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_rdata  out  64  load data, right-aligned, unselected bytes zero; 0 for stores and errors
resp_err  out  1  access out of range or crossing a word boundary

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. On reset_n low, state goes to IDLE immediately, which gives req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, and latency counter 0.
- Array contents are not reset. A reset in mid-operation discards the in-flight request; no partial write occurs unless the commit edge has already passed.
- FSM states:
  - IDLE: req_ready=1. On req_valid&&req_ready, capture addr, wen, wdata and wmask. If LATENCY==1, go to RESP; otherwise go to WAIT with counter=LATENCY-1.
  - WAIT: req_ready=0. Decrement the counter each cycle; on the edge where the counter==1, go to RESP.
  - RESP: req_ready=0, resp_valid=1. resp_rdata and resp_err are held stable until resp_valid&&resp_ready, then go to IDLE.
- A new request cannot be accepted in the same cycle a response handshakes; req_ready rises the cycle after. One outstanding request at most.
- Latency: resp_valid is first high exactly LATENCY cycles after the accepting edge.
- Commit edge: the edge entering RESP. On this edge, the store is written, load data is sampled, and the response registers are loaded. A load issued after a completed store to the same bytes returns the new data.
- Address decode:
  - off = req_addr - BASE
  - idx = off[log2(DEPTH)+2:3]
  - sh = off[2:0]
  - strobe = (wmask << sh), computed in 16 bits
- Error conditions: resp_err=1 if req_addr < BASE, off >= DEPTH*8, or strobe[15:8] != 0 (misaligned crossing). On error, no array write occurs and resp_rdata=0.
- Store: for each byte b with strobe[b]=1, mem[idx].byte[b] = wdata.byte[b-sh]. Other bytes are unchanged. resp_rdata=0.
- Load: resp_rdata = (mem[idx] >> 8*sh) with bytes whose wmask bit is 0 forced to 0. The responder does no sign extension; the LSU owns it.
- wmask values other than the four legal ones are applied literally as byte strobes (not flagged).
- resp_valid held while resp_ready=0 for any number of cycles; outputs must not change.

Decomposition:
- Shared package: lsu_mem_pkg with the state enum {IDLE, WAIT, RESP}, mask constants MASK_B=8'h01, MASK_H=8'h03, MASK_W=8'h0F, MASK_D=8'hFF, and the request/response struct typedefs, for reuse by the LSU-side initiator.
- One sub-module: lsu_mem_array (DEPTH x 64 synchronous-write, combinational-read byte-strobed array). The FSM, decode and alignment logic stay in the top.

Test Plan:
- Reset during WAIT: store to BASE+0x10, assert reset_n=0 one cycle after acceptance -> req_ready=1 and resp_valid=0 immediately; a later load of BASE+0x10 returns pre-reset contents.
- Dword store/load: store 0x1122334455667788 mask 0xFF at BASE+0x8 -> resp_valid exactly 2 cycles after accept, rdata=0, err=0; then load mask 0xFF -> rdata=0x1122334455667788.
- Byte/half lanes: store 0xAB mask 0x01 at BASE+0xD -> load BASE+0x8 mask 0xFF returns 0x1122AB4455667788; load BASE+0xE mask 0x03 returns 0x1122.
- Backpressure: hold resp_ready=0 for 5 cycles on a load -> resp_valid and resp_rdata stable, req_ready=0 throughout; handshake cycle is followed by req_ready=1 the next cycle.
- Errors: load at BASE-8, at BASE+DEPTH*8, and word load at BASE+0x6 (crossing) -> err=1, rdata=0; a store with the same crossing leaves memory unchanged.
- LATENCY=1 build: back-to-back loads -> each resp_valid 1 cycle after accept, throughput one request per 2 cycles with resp_ready tied high.

Source files
------------

// File: rtl/lsu_mem_pkg.sv
// Shared types for the LSU <-> memory responder path.
// Holds the responder state enum, the legal byte-length mask encodings,
// and the request/response structs so the LSU-side initiator can reuse them.
package lsu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Right-aligned byte-length masks: byte, half, word, dword.
    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
    localparam logic [7:0] MASK_D = 8'hFF;

    typedef struct packed {
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } mem_req_t;

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } mem_resp_t;

    // Turns an 8-bit byte mask into a 64-bit bit mask (one 0xFF lane per set bit).
    function automatic logic [63:0] expand_mask(input logic [7:0] m);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) begin
            r[8*b +: 8] = {8{m[b]}};
        end
        return r;
    endfunction

endpackage

// File: rtl/lsu_mem_array.sv
// DEPTH x 64-bit word array with byte-strobed synchronous write and
// combinational read. Contents are deliberately not reset.
// Ports:
//   clock   - write clock, rising edge
//   we      - write enable for this edge
//   idx     - word index, shared by read and write
//   strobe  - per-byte write enables, byte 0 = bits [7:0]
//   wdata   - write data, already aligned to the word lanes
//   rdata   - combinational read of mem[idx]
module lsu_mem_array #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [7:0]       strobe,
    input  logic [63:0]      wdata,
    output logic [63:0]      rdata
);

    logic [63:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        for (int b = 0; b < 8; b++) begin
            if (we && strobe[b]) begin
                mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/lsu_mem_responder.sv
// Memory-side responder for the LSU: accepts one byte-masked load/store,
// services it after LATENCY cycles against an internal word array, and
// returns load data (or a store ack) over a valid/ready response channel.
// Ports:
//   clock, reset_n              - clock and async active-low reset
//   req_valid/req_ready         - request handshake
//   req_addr/wen/wdata/wmask    - byte address, store flag, right-aligned data, byte-length mask
//   resp_valid/resp_ready       - response handshake
//   resp_rdata/resp_err         - right-aligned load data, range/crossing error
module lsu_mem_responder
    import lsu_mem_pkg::*;
#(
    parameter int          DEPTH   = 1024,
    parameter logic [63:0] BASE    = 64'h8000_0000,
    parameter int          LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic        req_wen,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int          IDX_W = $clog2(DEPTH);
    localparam int          CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [63:0] SPAN  = 64'(DEPTH) << 3;

    state_t           state, state_next;
    mem_req_t         req_q, cur;
    mem_resp_t        resp_q, resp_d;
    logic [CNT_W-1:0] cnt;
    logic             commit;
    logic             arr_we;
    logic [63:0]      off;
    logic [IDX_W-1:0] idx;
    logic [2:0]       sh;
    logic [15:0]      strobe;
    logic             err;
    logic [63:0]      arr_rdata;

    // With LATENCY==1 the commit edge is the accepting edge, so decode must
    // look at the live request while idle and at the captured one afterwards.
    always_comb begin
        if (state == IDLE) begin
            cur = '{req_addr, req_wen, req_wdata, req_wmask};
        end else begin
            cur = req_q;
        end
    end

    // Strobe is computed in 16 bits so a mask that runs past byte 7 shows up
    // in the upper half and flags a word-crossing access.
    assign off    = cur.addr - BASE;
    assign idx    = off[IDX_W+2:3];
    assign sh     = off[2:0];
    assign strobe = {8'h00, cur.wmask} << sh;
    assign err    = (cur.addr < BASE) || (off >= SPAN) || (strobe[15:8] != 8'h00);

    assign commit = (state != RESP) && (state_next == RESP);
    assign arr_we = commit && cur.wen && !err;

    lsu_mem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clock  (clock),
        .we     (arr_we),
        .idx    (idx),
        .strobe (strobe[7:0]),
        .wdata  (cur.wdata << {sh, 3'b000}),
        .rdata  (arr_rdata)
    );

    // Loads return the addressed bytes shifted down to bit 0 with unselected
    // lanes zeroed; stores and errors return zero data.
    always_comb begin
        resp_d.rdata = '0;
        resp_d.err   = err;
        if (!cur.wen && !err) begin
            resp_d.rdata = (arr_rdata >> {sh, 3'b000}) & expand_mask(cur.wmask);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request capture, latency countdown and response registers. The
    // response registers load only on the commit edge, so they stay stable
    // for as long as the consumer back-pressures.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            req_q  <= '0;
            cnt    <= '0;
            resp_q <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                req_q <= cur;
                cnt   <= CNT_W'(LATENCY - 1);
            end else if (state == WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (commit) begin
                resp_q <= resp_d;
            end
        end
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        resp_rdata = '0;
        resp_err   = 1'b0;
        if (state == RESP) begin
            resp_rdata = resp_q.rdata;
            resp_err   = resp_q.err;
        end
    end

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Self-checking bench for lsu_mem_responder: one LATENCY=2 instance driven
// by directed and random traffic against a byte-addressed reference model,
// plus a LATENCY=1 instance for back-to-back throughput.
module tb_lsu_mem_responder;
    import lsu_mem_pkg::*;

    localparam int          DEPTH = 1024;
    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam logic [63:0] SPAN  = 64'(DEPTH) * 64'd8;
    localparam int          LAT   = 2;

    logic        clock;
    logic        reset_n;
    logic        req_valid, req_ready, req_wen;
    logic [63:0] req_addr, req_wdata;
    logic [7:0]  req_wmask;
    logic        resp_valid, resp_ready, resp_err;
    logic [63:0] resp_rdata;

    logic        l1_req_valid, l1_req_ready, l1_req_wen;
    logic [63:0] l1_req_addr, l1_req_wdata;
    logic [7:0]  l1_req_wmask;
    logic        l1_resp_valid, l1_resp_ready, l1_resp_err;
    logic [63:0] l1_resp_rdata;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference memory: one entry per byte, keyed by offset from BASE.
    logic [7:0] model_mem [longint];

    lsu_mem_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(LAT)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wen    (req_wen),
        .req_wdata  (req_wdata),
        .req_wmask  (req_wmask),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    lsu_mem_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(1)) dut_l1 (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (l1_req_valid),
        .req_ready  (l1_req_ready),
        .req_addr   (l1_req_addr),
        .req_wen    (l1_req_wen),
        .req_wdata  (l1_req_wdata),
        .req_wmask  (l1_req_wmask),
        .resp_valid (l1_resp_valid),
        .resp_ready (l1_resp_ready),
        .resp_rdata (l1_resp_rdata),
        .resp_err   (l1_resp_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=still_running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // An access errors if it starts outside the array or any selected byte
    // lies beyond the end of the starting word.
    function automatic logic model_err(input logic [63:0] addr, input logic [7:0] wmask);
        logic [63:0] off;
        if (addr < BASE) return 1'b1;
        off = addr - BASE;
        if (off >= SPAN) return 1'b1;
        for (int b = 0; b < 8; b++) begin
            if (wmask[b] && (int'(off[2:0]) + b) >= 8) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [63:0] model_load(input logic [63:0] addr, input logic [7:0] wmask);
        logic [63:0] r;
        longint      k;
        r = '0;
        for (int b = 0; b < 8; b++) begin
            k = longint'(addr - BASE) + longint'(b);
            if (wmask[b] && model_mem.exists(k)) r[8*b +: 8] = model_mem[k];
        end
        return r;
    endfunction

    task automatic model_store(input logic [63:0] addr, input logic [63:0] wdata, input logic [7:0] wmask);
        for (int b = 0; b < 8; b++) begin
            if (wmask[b]) model_mem[longint'(addr - BASE) + longint'(b)] = wdata[8*b +: 8];
        end
    endtask

    // One full transaction on the LATENCY=2 instance: latency, response
    // values, stability under back-pressure and the post-handshake gap.
    task automatic applyStimulus(input logic [63:0] addr, input logic wen, input logic [63:0] wdata,
                                 input logic [7:0] wmask, input int hold, output logic [63:0] got);
        logic        exp_err;
        logic [63:0] exp_rdata;
        int          lat;
        exp_err   = model_err(addr, wmask);
        exp_rdata = (wen || exp_err) ? 64'h0 : model_load(addr, wmask);
        @(negedge clock);
        checkBit("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1;
        req_addr  = addr;
        req_wen   = wen;
        req_wdata = wdata;
        req_wmask = wmask;
        lat = 0;
        do begin
            @(posedge clock);
            #1;
            lat++;
            if (lat == 1) req_valid = 1'b0;
        end while (!resp_valid && lat < 20);
        checkOutput("latency", 64'(lat), 64'(LAT));
        checkOutput("rdata", resp_rdata, exp_rdata);
        checkBit("err", resp_err, exp_err);
        got = resp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            #1;
            checkBit("hold_valid", resp_valid, 1'b1);
            checkBit("hold_req_ready", req_ready, 1'b0);
            checkOutput("hold_rdata", resp_rdata, exp_rdata);
            checkBit("hold_err", resp_err, exp_err);
        end
        resp_ready = 1'b1;
        @(posedge clock);
        #1;
        resp_ready = 1'b0;
        checkBit("post_hs_valid", resp_valid, 1'b0);
        checkBit("post_hs_req_ready", req_ready, 1'b1);
        if (wen && !exp_err) model_store(addr, wdata, wmask);
    endtask

    // Store accepted, then reset asserted during WAIT before the commit edge.
    task automatic resetDuringWait(input logic [63:0] addr, input logic [63:0] wdata);
        @(negedge clock);
        req_valid = 1'b1;
        req_addr  = addr;
        req_wen   = 1'b1;
        req_wdata = wdata;
        req_wmask = MASK_D;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        checkBit("wait_valid", resp_valid, 1'b0);
        reset_n = 1'b0;
        #1;
        checkBit("rst_req_ready", req_ready, 1'b1);
        checkBit("rst_resp_valid", resp_valid, 1'b0);
        checkOutput("rst_rdata", resp_rdata, 64'h0);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    logic [63:0] got;
    logic [7:0]  mask_tab [5];
    logic [63:0] l1_addr [6];
    logic        l1_wen  [6];
    logic [63:0] l1_wdat [6];
    logic [7:0]  l1_mask [6];
    logic [63:0] l1_exp  [6];
    logic [63:0] w0, w1;

    initial begin
        logic [63:0] a;
        mask_tab[0] = MASK_B;
        mask_tab[1] = MASK_H;
        mask_tab[2] = MASK_W;
        mask_tab[3] = MASK_D;
        mask_tab[4] = 8'h05;

        reset_n       = 1'b1;
        req_valid     = 1'b0;
        req_addr      = '0;
        req_wen       = 1'b0;
        req_wdata     = '0;
        req_wmask     = '0;
        resp_ready    = 1'b0;
        l1_req_valid  = 1'b0;
        l1_req_addr   = '0;
        l1_req_wen    = 1'b0;
        l1_req_wdata  = '0;
        l1_req_wmask  = '0;
        l1_resp_ready = 1'b1;

        #2 reset_n = 1'b0;
        #1;
        checkBit("reset_req_ready", req_ready, 1'b1);
        checkBit("reset_resp_valid", resp_valid, 1'b0);
        checkOutput("reset_rdata", resp_rdata, 64'h0);
        checkBit("reset_err", resp_err, 1'b0);
        checkBit("reset_l1_req_ready", l1_req_ready, 1'b1);
        checkBit("reset_l1_resp_valid", l1_resp_valid, 1'b0);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // Give every byte of the first 32 words a known value.
        for (int w = 0; w < 32; w++) begin
            applyStimulus(BASE + 64'(8 * w), 1'b1, {$urandom, $urandom}, MASK_D, 0, got);
        end

        applyStimulus(BASE + 64'h8, 1'b1, 64'h1122334455667788, MASK_D, 0, got);
        checkOutput("dword_store_rdata", got, 64'h0);
        applyStimulus(BASE + 64'h8, 1'b0, 64'h0, MASK_D, 0, got);
        checkOutput("dword_load", got, 64'h1122334455667788);

        applyStimulus(BASE + 64'hD, 1'b1, 64'hAB, MASK_B, 0, got);
        applyStimulus(BASE + 64'h8, 1'b0, 64'h0, MASK_D, 0, got);
        checkOutput("byte_lane_load", got, 64'h1122AB4455667788);
        applyStimulus(BASE + 64'hE, 1'b0, 64'h0, MASK_H, 0, got);
        checkOutput("half_lane_load", got, 64'h1122);

        applyStimulus(BASE + 64'h8, 1'b0, 64'h0, MASK_D, 5, got);
        checkOutput("backpressure_load", got, 64'h1122AB4455667788);

        applyStimulus(BASE - 64'h8, 1'b0, 64'h0, MASK_D, 0, got);
        checkOutput("err_below_rdata", got, 64'h0);
        applyStimulus(BASE + SPAN, 1'b0, 64'h0, MASK_D, 0, got);
        checkOutput("err_above_rdata", got, 64'h0);
        applyStimulus(BASE + 64'h6, 1'b0, 64'h0, MASK_W, 0, got);
        checkOutput("err_cross_rdata", got, 64'h0);
        applyStimulus(BASE + 64'h6, 1'b1, 64'hDEAD_BEEF, MASK_W, 0, got);
        applyStimulus(BASE + 64'h0, 1'b0, 64'h0, MASK_D, 0, got);
        applyStimulus(BASE + 64'h8, 1'b0, 64'h0, MASK_D, 0, got);
        checkOutput("cross_store_no_write", got, 64'h1122AB4455667788);

        resetDuringWait(BASE + 64'h10, 64'hCAFE_F00D_0BAD_BEEF);
        applyStimulus(BASE + 64'h10, 1'b0, 64'h0, MASK_D, 0, got);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 1) == 0) a = BASE - 64'(8 * $urandom_range(1, 4));
                else                           a = BASE + SPAN + 64'(8 * $urandom_range(0, 3));
            end else begin
                a = BASE + 64'(8 * $urandom_range(0, 31)) + 64'($urandom_range(0, 7));
            end
            applyStimulus(a, 1'($urandom_range(0, 1)), {$urandom, $urandom},
                          mask_tab[$urandom_range(0, 4)], int'($urandom_range(0, 3)), got);
        end

        // LATENCY=1: two stores, then back-to-back loads with req_valid held high.
        w0 = {$urandom, $urandom};
        w1 = {$urandom, $urandom};
        l1_addr[0] = BASE;          l1_wen[0] = 1'b1; l1_wdat[0] = w0;  l1_mask[0] = MASK_D; l1_exp[0] = 64'h0;
        l1_addr[1] = BASE + 64'h8;  l1_wen[1] = 1'b1; l1_wdat[1] = w1;  l1_mask[1] = MASK_D; l1_exp[1] = 64'h0;
        l1_addr[2] = BASE;          l1_wen[2] = 1'b0; l1_wdat[2] = '0;  l1_mask[2] = MASK_D; l1_exp[2] = w0;
        l1_addr[3] = BASE + 64'h8;  l1_wen[3] = 1'b0; l1_wdat[3] = '0;  l1_mask[3] = MASK_D; l1_exp[3] = w1;
        l1_addr[4] = BASE + 64'h3;  l1_wen[4] = 1'b0; l1_wdat[4] = '0;  l1_mask[4] = MASK_B; l1_exp[4] = {56'h0, w0[31:24]};
        l1_addr[5] = BASE + 64'hC;  l1_wen[5] = 1'b0; l1_wdat[5] = '0;  l1_mask[5] = MASK_W; l1_exp[5] = {32'h0, w1[63:32]};

        @(negedge clock);
        l1_req_valid = 1'b1;
        l1_req_addr  = l1_addr[0];
        l1_req_wen   = l1_wen[0];
        l1_req_wdata = l1_wdat[0];
        l1_req_wmask = l1_mask[0];
        for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            #1;
            checkBit("l1_resp_valid", l1_resp_valid, 1'b1);
            checkBit("l1_req_ready_busy", l1_req_ready, 1'b0);
            checkOutput("l1_rdata", l1_resp_rdata, l1_exp[i]);
            checkBit("l1_err", l1_resp_err, 1'b0);
            if (i < 5) begin
                l1_req_addr  = l1_addr[i+1];
                l1_req_wen   = l1_wen[i+1];
                l1_req_wdata = l1_wdat[i+1];
                l1_req_wmask = l1_mask[i+1];
            end else begin
                l1_req_valid = 1'b0;
            end
            @(posedge clock);
            #1;
            checkBit("l1_post_hs_valid", l1_resp_valid, 1'b0);
            checkBit("l1_post_hs_ready", l1_req_ready, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
